// File: rtl/column_scheduler_if.sv
// -----------------------------------------------------------------------------
// column_scheduler_if
//
// Groups the game-control and column-array signals of column_scheduler into
// one bundle. The clock and the reset stay plain ports on the scheduler.
//
//   slave  (scheduler side) : inputs  start, key_valid, key_code,
//                                     col_correct, col_game_over
//                             outputs col_reset, col_user_input, col_active,
//                                     score, game_over, state
//   master (front end / bench side): the same signals, directions reversed
// -----------------------------------------------------------------------------
interface column_scheduler_if #(
    parameter int NUM_COLUMNS = 4,
    parameter int SCORE_WIDTH = 8
);
    logic                   start;
    logic                   key_valid;
    logic [7:0]             key_code;
    logic [NUM_COLUMNS-1:0] col_correct;
    logic [NUM_COLUMNS-1:0] col_game_over;
    logic [NUM_COLUMNS-1:0] col_reset;
    logic [7:0]             col_user_input;
    logic [NUM_COLUMNS-1:0] col_active;
    logic [SCORE_WIDTH-1:0] score;
    logic                   game_over;
    logic [1:0]             state;

    modport master (
        output start, key_valid, key_code, col_correct, col_game_over,
        input  col_reset, col_user_input, col_active, score, game_over, state
    );

    modport slave (
        input  start, key_valid, key_code, col_correct, col_game_over,
        output col_reset, col_user_input, col_active, score, game_over, state
    );
endinterface

// File: rtl/column_scheduler.sv
// -----------------------------------------------------------------------------
// column_scheduler
//
// Sequencer for the FlippyBit playfield. It launches NUM_COLUMNS columns one
// after another, SPAWN_INTERVAL cycles apart. It forwards each key to the
// columns as a one-cycle code. It credits and respawns the lowest-index
// column that reports a correct match. Play freezes when any live column
// reports game over.
//
// Ports:
//   clock           in   system clock, rising edge
//   reset_signal_n  in   asynchronous active-low reset
//   bus (slave)     control/column bundle, see column_scheduler_if
//     start           in   one-cycle pulse: begin or restart a game
//     key_valid       in   one-cycle strobe qualifying key_code
//     key_code        in   ASCII code of the pressed key
//     col_correct     in   per-column correct flag
//     col_game_over   in   per-column game-over flag
//     col_reset       out  per-column active-high column reset
//     col_user_input  out  key code broadcast to the columns for one cycle
//     col_active      out  per-column launched / display enable
//     score           out  current score
//     game_over       out  high while in OVER
//     state           out  IDLE=0, RUN=1, OVER=2
//
// Optional feature: define COLUMN_SCHEDULER_MISS_PENALTY_EN to deduct one
// point (floored at 0) for every key not followed by a credit within
// MATCH_WINDOW cycles. When the macro is undefined, MATCH_WINDOW is unused.
// -----------------------------------------------------------------------------
module column_scheduler #(
    parameter int NUM_COLUMNS    = 4,
    parameter int SPAWN_INTERVAL = 50000000,
    parameter int RESPAWN_PULSE  = 2,
    parameter int SCORE_WIDTH    = 8,
    parameter int MATCH_WINDOW   = 2
) (
    input  logic               clock,
    input  logic               reset_signal_n,
    column_scheduler_if.slave  bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_OVER = 2'd2;

    localparam int IDX_W   = $clog2(NUM_COLUMNS + 1);
    localparam int SPAWN_W = (SPAWN_INTERVAL > 1) ? $clog2(SPAWN_INTERVAL) : 1;
    localparam int PULSE_W = $clog2(RESPAWN_PULSE + 1);

    logic [1:0]             r_state;
    logic [NUM_COLUMNS-1:0] r_active;
    logic [PULSE_W-1:0]     r_pulse_cnt [NUM_COLUMNS];
    logic [SPAWN_W-1:0]     r_spawn_cnt;
    logic [IDX_W-1:0]       r_next_idx;
    logic [SCORE_WIDTH-1:0] r_score;
    logic [7:0]             r_user_input;

    logic [NUM_COLUMNS-1:0] w_col_reset;
    logic [NUM_COLUMNS-1:0] w_qualified;
    logic [NUM_COLUMNS-1:0] w_correct_q;
    logic [NUM_COLUMNS-1:0] w_credit_oh;
    logic [NUM_COLUMNS-1:0] w_launch;
    logic                   w_run;
    logic                   w_go_hit;
    logic                   w_credit;
    logic                   w_unlaunched;
    logic                   w_spawn_fire;

    function automatic logic [SCORE_WIDTH-1:0] sat_inc(input logic [SCORE_WIDTH-1:0] v);
        return (&v) ? v : v + SCORE_WIDTH'(1);
    endfunction

`ifdef COLUMN_SCHEDULER_MISS_PENALTY_EN
    localparam int WIN_W = $clog2(MATCH_WINDOW + 1);

    logic [WIN_W-1:0] r_win_cnt;
    logic             w_miss;

    function automatic logic [SCORE_WIDTH-1:0] floor_dec(input logic [SCORE_WIDTH-1:0] v);
        return (v == '0) ? v : v - SCORE_WIDTH'(1);
    endfunction

    // A pending window is a miss when it runs out without a credit. It is
    // also a miss when a new key cuts it short before any credit arrives.
    always_comb begin
        w_miss = (r_win_cnt != '0) && !w_credit &&
                 ((r_win_cnt == WIN_W'(1)) || bus.key_valid);
    end
`else
    logic w_unused_match_window;
    assign w_unused_match_window = (MATCH_WINDOW != 0);
`endif

    // A column is held in reset until it is launched, and again during each
    // launch or respawn pulse.
    always_comb begin
        for (int k = 0; k < NUM_COLUMNS; k++) begin
            w_col_reset[k] = (r_state == ST_IDLE) || !r_active[k] ||
                             (r_pulse_cnt[k] != '0);
        end
    end

    assign w_qualified  = r_active & ~w_col_reset;
    assign w_correct_q  = bus.col_correct & w_qualified;
    // Isolate the lowest set bit: only one credit is serviced per cycle.
    assign w_credit_oh  = w_correct_q & (~w_correct_q + NUM_COLUMNS'(1));

    // A start pulse overrides everything else, and game over overrides
    // credits and launches.
    assign w_run        = (r_state == ST_RUN) && !bus.start;
    assign w_go_hit     = w_run && (|(bus.col_game_over & w_qualified));
    assign w_credit     = w_run && !w_go_hit && (|w_correct_q);
    assign w_unlaunched = (r_next_idx < IDX_W'(NUM_COLUMNS));
    assign w_spawn_fire = w_run && !w_go_hit && w_unlaunched &&
                          (r_spawn_cnt == SPAWN_W'(SPAWN_INTERVAL - 1));

    always_comb begin
        w_launch = '0;
        for (int k = 0; k < NUM_COLUMNS; k++) begin
            if (w_spawn_fire && (r_next_idx == IDX_W'(k))) begin
                w_launch[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_signal_n) begin
        if (!reset_signal_n) begin
            r_state      <= ST_IDLE;
            r_active     <= '0;
            r_spawn_cnt  <= '0;
            r_next_idx   <= '0;
            r_score      <= '0;
            r_user_input <= 8'h00;
            for (int k = 0; k < NUM_COLUMNS; k++) begin
                r_pulse_cnt[k] <= '0;
            end
`ifdef COLUMN_SCHEDULER_MISS_PENALTY_EN
            r_win_cnt    <= '0;
`endif
        end else begin
            r_user_input <= 8'h00;
            for (int k = 0; k < NUM_COLUMNS; k++) begin
                if (r_pulse_cnt[k] != '0) begin
                    r_pulse_cnt[k] <= r_pulse_cnt[k] - PULSE_W'(1);
                end
            end

            if (bus.start) begin
                // Fresh game: all columns dropped, column 0 launched at once.
                r_state        <= ST_RUN;
                r_score        <= '0;
                r_active       <= NUM_COLUMNS'(1);
                r_spawn_cnt    <= '0;
                r_next_idx     <= IDX_W'(1);
                for (int k = 0; k < NUM_COLUMNS; k++) begin
                    r_pulse_cnt[k] <= '0;
                end
                r_pulse_cnt[0] <= PULSE_W'(RESPAWN_PULSE);
`ifdef COLUMN_SCHEDULER_MISS_PENALTY_EN
                r_win_cnt      <= '0;
`endif
            end else if (r_state == ST_RUN) begin
                if (w_go_hit) begin
                    r_state <= ST_OVER;
`ifdef COLUMN_SCHEDULER_MISS_PENALTY_EN
                    r_win_cnt <= '0;
`endif
                end else begin
                    if (bus.key_valid) begin
                        r_user_input <= bus.key_code;
                    end

                    if (w_credit) begin
                        r_score <= sat_inc(r_score);
`ifdef COLUMN_SCHEDULER_MISS_PENALTY_EN
                    end else if (w_miss) begin
                        r_score <= floor_dec(r_score);
`endif
                    end

`ifdef COLUMN_SCHEDULER_MISS_PENALTY_EN
                    if (bus.key_valid) begin
                        r_win_cnt <= WIN_W'(MATCH_WINDOW);
                    end else if (w_credit || w_miss) begin
                        r_win_cnt <= '0;
                    end else if (r_win_cnt != '0) begin
                        r_win_cnt <= r_win_cnt - WIN_W'(1);
                    end
`endif

                    for (int k = 0; k < NUM_COLUMNS; k++) begin
                        if ((w_credit && w_credit_oh[k]) || w_launch[k]) begin
                            r_pulse_cnt[k] <= PULSE_W'(RESPAWN_PULSE);
                        end
                        if (w_launch[k]) begin
                            r_active[k] <= 1'b1;
                        end
                    end

                    // The spawn timer runs only while some column is unlaunched.
                    if (w_unlaunched) begin
                        if (w_spawn_fire) begin
                            r_spawn_cnt <= '0;
                            r_next_idx  <= r_next_idx + IDX_W'(1);
                        end else begin
                            r_spawn_cnt <= r_spawn_cnt + SPAWN_W'(1);
                        end
                    end
                end
            end
        end
    end

    assign bus.col_reset      = w_col_reset;
    assign bus.col_active     = r_active;
    assign bus.col_user_input = r_user_input;
    assign bus.score          = r_score;
    assign bus.game_over      = (r_state == ST_OVER);
    assign bus.state          = r_state;

endmodule

// File: tb/tb_column_scheduler.sv
// -----------------------------------------------------------------------------
// tb_column_scheduler
//
// Directed bench for column_scheduler with NUM_COLUMNS=2, SPAWN_INTERVAL=10
// and RESPAWN_PULSE=2. Inputs change 1 time unit after each rising edge, and
// outputs are checked at that same point.
// -----------------------------------------------------------------------------
module tb_column_scheduler;

    logic clk = 1'b0;
    logic rst_n;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    column_scheduler_if #(.NUM_COLUMNS(2), .SCORE_WIDTH(8)) bus ();

    column_scheduler #(
        .NUM_COLUMNS    (2),
        .SPAWN_INTERVAL (10),
        .RESPAWN_PULSE  (2),
        .SCORE_WIDTH    (8),
        .MATCH_WINDOW   (2)
    ) dut (
        .clock          (clk),
        .reset_signal_n (rst_n),
        .bus            (bus.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One credit on column 0, then enough idle cycles for its respawn pulse.
    task automatic credit_col0();
        bus.col_correct = 2'b01;
        tick();
        bus.col_correct = 2'b00;
        tick();
        tick();
    endtask

    initial begin
        rst_n             = 1'b0;
        bus.start         = 1'b0;
        bus.key_valid     = 1'b0;
        bus.key_code      = 8'h00;
        bus.col_correct   = 2'b00;
        bus.col_game_over = 2'b00;
        tick();
        tick();

        check("rst_state",     32'(bus.state),          32'd0);
        check("rst_col_reset", 32'(bus.col_reset),      32'h3);
        check("rst_col_active",32'(bus.col_active),     32'h0);
        check("rst_user_input",32'(bus.col_user_input), 32'h00);
        check("rst_score",     32'(bus.score),          32'h00);
        check("rst_game_over", 32'(bus.game_over),      32'd0);

        rst_n = 1'b1;
        tick();

        // Start and staggered launch.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("start_state",   32'(bus.state),      32'd1);
        check("start_active",  32'(bus.col_active), 32'h1);
        check("start_reset_c1",32'(bus.col_reset),  32'h3);
        tick();
        check("start_reset_c2",32'(bus.col_reset),  32'h3);
        tick();
        check("start_reset_c3",32'(bus.col_reset),  32'h2);
        repeat (7) tick();
        check("pre_launch1_active", 32'(bus.col_active), 32'h1);
        tick();
        check("launch1_active", 32'(bus.col_active), 32'h3);
        check("launch1_reset",  32'(bus.col_reset),  32'h2);
        tick();
        tick();
        check("launch1_reset_done", 32'(bus.col_reset), 32'h0);

        // Key routing and a single credit on column 1.
        bus.key_valid = 1'b1;
        bus.key_code  = 8'h41;
        tick();
        bus.key_valid = 1'b0;
        bus.key_code  = 8'h00;
        check("key_41_cycle1", 32'(bus.col_user_input), 32'h41);
        tick();
        check("key_41_cycle2", 32'(bus.col_user_input), 32'h00);
        bus.col_correct = 2'b10;
        tick();
        bus.col_correct = 2'b00;
        check("credit1_score", 32'(bus.score),     32'h01);
        check("credit1_reset", 32'(bus.col_reset), 32'h2);
        tick();
        check("credit1_reset_c2", 32'(bus.col_reset), 32'h2);
        tick();
        check("credit1_reset_end", 32'(bus.col_reset), 32'h0);

        // Two simultaneous correct flags: serviced lowest index first.
        bus.col_correct = 2'b11;
        tick();
        check("dual_score_a", 32'(bus.score),     32'h02);
        check("dual_reset_a", 32'(bus.col_reset), 32'h1);
        tick();
        bus.col_correct = 2'b00;
        check("dual_score_b", 32'(bus.score),     32'h03);
        check("dual_reset_b", 32'(bus.col_reset), 32'h3);
        tick();
        check("dual_reset_c", 32'(bus.col_reset), 32'h2);
        tick();
        check("dual_reset_d", 32'(bus.col_reset), 32'h0);
        check("dual_score_end", 32'(bus.score),   32'h03);

        // Drive the score to all-ones and confirm saturation.
        for (int i = 0; i < 252; i++) credit_col0();
        check("score_ff", 32'(bus.score), 32'hFF);
        bus.col_correct = 2'b01;
        tick();
        bus.col_correct = 2'b00;
        check("sat_score", 32'(bus.score),     32'hFF);
        check("sat_reset", 32'(bus.col_reset), 32'h1);
        tick();
        tick();

        // Game over wins over a same-cycle credit.
        bus.col_game_over = 2'b10;
        bus.col_correct   = 2'b01;
        tick();
        bus.col_game_over = 2'b00;
        bus.col_correct   = 2'b00;
        check("go_state",     32'(bus.state),      32'd2);
        check("go_flag",      32'(bus.game_over),  32'd1);
        check("go_score",     32'(bus.score),      32'hFF);
        check("go_active",    32'(bus.col_active), 32'h3);
        check("go_no_respawn",32'(bus.col_reset),  32'h0);
        bus.key_valid = 1'b1;
        bus.key_code  = 8'h42;
        tick();
        bus.key_valid = 1'b0;
        bus.key_code  = 8'h00;
        check("over_key_c1", 32'(bus.col_user_input), 32'h00);
        tick();
        check("over_key_c2", 32'(bus.col_user_input), 32'h00);
        check("over_hold",   32'(bus.state),          32'd2);

        // Restart from OVER.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("restart_score",  32'(bus.score),      32'h00);
        check("restart_active", 32'(bus.col_active), 32'h1);
        check("restart_state",  32'(bus.state),      32'd1);
        check("restart_go",     32'(bus.game_over),  32'd0);
        tick();
        tick();

`ifdef COLUMN_SCHEDULER_MISS_PENALTY_EN
        // Miss penalty: an uncredited key costs one point, floored at 0.
        repeat (3) credit_col0();
        check("miss_pre_score", 32'(bus.score), 32'h03);
        bus.key_valid = 1'b1;
        bus.key_code  = 8'h44;
        tick();
        bus.key_valid = 1'b0;
        tick();
        check("miss_window_open", 32'(bus.score), 32'h03);
        tick();
        check("miss_score_2", 32'(bus.score), 32'h02);
        repeat (2) begin
            bus.key_valid = 1'b1;
            tick();
            bus.key_valid = 1'b0;
            tick();
            tick();
        end
        check("miss_score_0", 32'(bus.score), 32'h00);
        bus.key_valid = 1'b1;
        tick();
        bus.key_valid = 1'b0;
        tick();
        tick();
        check("miss_floor", 32'(bus.score), 32'h00);
        bus.key_code = 8'h00;
`endif

        // Asynchronous reset in the middle of a run.
        bus.col_correct = 2'b01;
        tick();
        bus.col_correct = 2'b00;
        check("pre_rst_score", 32'(bus.score), 32'h01);
        bus.key_valid = 1'b1;
        bus.key_code  = 8'h43;
        tick();
        bus.key_valid = 1'b0;
        bus.key_code  = 8'h00;
        check("pre_rst_key",   32'(bus.col_user_input), 32'h43);
        check("pre_rst_state", 32'(bus.state),          32'd1);
        #2;
        rst_n = 1'b0;
        #2;
        check("async_state",      32'(bus.state),          32'd0);
        check("async_col_reset",  32'(bus.col_reset),      32'h3);
        check("async_col_active", 32'(bus.col_active),     32'h0);
        check("async_user_input", 32'(bus.col_user_input), 32'h00);
        check("async_score",      32'(bus.score),          32'h00);
        check("async_game_over",  32'(bus.game_over),      32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/column_scheduler.md
# column_scheduler

Sequencer for the FlippyBit playfield. It owns the per-column reset lines of NUM_COLUMNS `Column` instances and launches them staggered in time. It routes each keypress to the columns as a one-cycle code, credits and respawns the column that matched, and freezes play when any live column reports game over. It sits between the keyboard/switch front end and the column array, and feeds the score and status to the display logic.

## Interface

Parameters:
- NUM_COLUMNS, 4, number of `Column` instances sequenced (2..8)
- SPAWN_INTERVAL, 50000000, clock cycles between successive column launches
- RESPAWN_PULSE, 2, cycles a column's reset is held high on launch or respawn (≥1)
- SCORE_WIDTH, 8, score register width
- MATCH_WINDOW, 2, cycles after a key in which a correct flag is credited to that key (used only with the macro)

Ports:
- clock  in  1  system clock, all state on rising edge
- reset_signal_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins or restarts a game
- key_valid  in  1  one-cycle strobe; key_code valid
- key_code  in  8  ASCII code of the pressed key
- col_correct  in  NUM_COLUMNS  per-column correct flag from `Column`
- col_game_over  in  NUM_COLUMNS  per-column game_over flag from `Column`
- col_reset  out  NUM_COLUMNS  per-column active-high reset to `Column`
- col_user_input  out  8  broadcast key code to all columns
- col_active  out  NUM_COLUMNS  column is launched; display enable
- score  out  SCORE_WIDTH  current score
- game_over  out  1  high while in OVER
- state  out  2  IDLE=0, RUN=1, OVER=2

## Operation

- States: IDLE, RUN, OVER.
- **IDLE**
  - All col_reset=1, col_active=0.
  - start → RUN, score cleared, column 0 launched.
- **Launch of column k**
  - col_active[k]=1.
  - col_reset[k]=1 for RESPAWN_PULSE cycles.
  - Spawn timer cleared.
- **Spawn timer**
  - Counts in RUN while any column is unlaunched.
  - At SPAWN_INTERVAL-1 it launches the next column index.
  - Stops once all columns are launched.
- **Flag qualification**: col_correct and col_game_over bits are ignored when the column is inactive or its col_reset is high.
- **Key routing**
  - key_valid in RUN → col_user_input=key_code for exactly the next cycle; otherwise 8'h00.
  - key_valid in IDLE/OVER is ignored.
- **Credit**
  - Per cycle, only the lowest-index qualified col_correct is serviced.
  - score+1, saturating at all-ones.
  - That column is respawned (reset pulse, stays active).
  - Other asserting columns are serviced on later cycles.
- **Game over**
  - Any qualified col_game_over in RUN → OVER.
  - Game over has priority over a credit in the same cycle.
- **OVER**
  - score frozen, col_active held, col_user_input=0, spawn timer stopped.
  - start → RUN with score cleared, all columns deactivated, column 0 launched.
- **start during RUN**: same restart as from OVER.

## Timing

- **Reset values**: state=IDLE, col_reset=all 1, col_active=0, col_user_input=0, score=0, game_over=0, spawn timer=0.
- **start sampled high at edge n**
  - state=RUN, col_active[0]=1 and col_reset[0]=1 from n+1.
  - col_reset[0] falls at n+1+RESPAWN_PULSE.
- **Next launch**: column k+1 launches SPAWN_INTERVAL cycles after column k's launch edge.
- **Key path**: key_valid at edge n → col_user_input valid during cycle n+1 only.
- **Credit path**
  - Qualified col_correct at edge n → score updated and col_reset[k]=1 from n+1.
  - The flag stays unqualified for RESPAWN_PULSE cycles.
- **Game-over path**: qualified col_game_over at edge n → game_over=1 and state=OVER from n+1.
- **Reset assertion**: mid-operation, all outputs go to reset values immediately (asynchronously), not at the next edge.

## Configuration

- **COLUMN_SCHEDULER_MISS_PENALTY_EN defined**
  - Each RUN-state key_valid opens a MATCH_WINDOW-cycle window starting at the cycle col_user_input is driven.
  - If no credit occurs within the window, score−1, floored at 0.
  - A new key_valid restarts the window and first evaluates the pending one.
- **Not defined**: misses have no effect; MATCH_WINDOW is unused.

## Test plan

Parameters for all scenarios: NUM_COLUMNS=2, SPAWN_INTERVAL=10, RESPAWN_PULSE=2.

1. Reset release then start pulse → col_active=2'b01 next cycle, col_reset[0] high 2 cycles, col_active=2'b11 10 cycles after the first launch.
2. key_valid with key_code=8'h41 in RUN → col_user_input=8'h41 one cycle then 8'h00; col_correct[1]=1 → score 0→1, col_reset[1] high 2 cycles.
3. col_correct=2'b11 same cycle → score +1 twice on consecutive cycles (column 0 first), each column respawned once.
4. col_game_over[1]=1 with col_correct[0]=1 same cycle → state=OVER, game_over=1, score unchanged; further keys give col_user_input=0.
5. score at 8'hFF plus credit → stays 8'hFF; start in OVER → score=0, col_active=2'b01.
6. With COLUMN_SCHEDULER_MISS_PENALTY_EN: score=3, key with no correct within 2 cycles → score=2; at score=0 → stays 0. Reset asserted mid-RUN → all outputs at reset values without waiting for a clock edge.
